// File: rtl/sr_flop_bank.sv
// sr_flop_bank: bank of WIDTH independent clocked SR flops.
// Each bit has async active-high reset and a deterministic policy for S=R=1.
// Optional macro SRFF_STICKY_ERR_EN adds err_sticky. It latches any S=R=1
// seen on any bit and clears only on reset.

module sr_flop_bit #(
  parameter int   ILLEGAL_MODE = 0,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sr_i,   // {S,R}
  output logic       q_o,
  output logic       ill_o
);
  logic q_q, q_d, ill_q, ill_d;

  // next state from the sampled {S,R}; modes outside 0..3 fall back to hold
  always_comb begin
    q_d   = q_q;
    ill_d = 1'b0;
    case (sr_i)
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: begin
        ill_d = 1'b1;
        case (ILLEGAL_MODE)
          1:       q_d = ~q_q;
          2:       q_d = 1'b0;
          3:       q_d = 1'b1;
          default: q_d = q_q;
        endcase
      end
      default: q_d = q_q;
    endcase
  end

  // state and flag registers; reset wins over any command on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      ill_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ill_q <= ill_d;
    end
  end

  assign q_o   = q_q;
  assign ill_o = ill_q;
endmodule

module sr_flop_bank #(
  parameter int               WIDTH        = 1,
  parameter int               ILLEGAL_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WIDTH-1:0] sr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar,
`ifdef SRFF_STICKY_ERR_EN
  output logic               err_sticky,
`endif
  output logic [WIDTH-1:0]   illegal
);
  logic [WIDTH-1:0] hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_flop_bit #(
      .ILLEGAL_MODE (ILLEGAL_MODE),
      .RESET_VAL    (RESET_VAL[i])
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .sr_i  (sr[2*i+1 -: 2]),
      .q_o   (q[i]),
      .ill_o (illegal[i])
    );
    assign hit[i] = &sr[2*i+1 -: 2];
  end

  // qbar is derived, never stored, so it can never agree with q
  assign qbar = ~q;

`ifdef SRFF_STICKY_ERR_EN
  logic err_q, err_d;

  always_comb err_d = err_q | (|hit);

  // sticky error: set by any S=R=1 sample, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_sticky = err_q;
`else
  logic unused_hit;
  assign unused_hit = |hit;
`endif
endmodule

// File: tb/tb_sr_flop_bank.sv
// Bench for sr_flop_bank: five instances with different width, mode and reset value.
// Directed steps run first, then random commands with async reset pulses.
// Everything is compared against a per-bit rule model.
`timescale 1ns/1ps
module tb_sr_flop_bank;
  localparam int N = 5;
  localparam int          MODE [N] = '{0, 1, 3, 2, 5};
  localparam int          W    [N] = '{1, 1, 4, 3, 2};
  localparam logic [7:0]  RV   [N] = '{8'h00, 8'h00, 8'h00, 8'h05, 8'h02};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd [N];
  logic [7:0]  oq [N], oqb [N], oil [N];
  logic        ost [N];
  logic [7:0]  mq [N], mi [N];
  logic        ms [N];
  int checks = 0, errors = 0;

  logic [0:0] qa, qba, ila, qb, qbb, ilb;
  logic [3:0] qc, qbc, ilc;
  logic [2:0] qd, qbd, ild;
  logic [1:0] qe, qbe, ile;

  always #10 clk = ~clk;

`ifdef SRFF_STICKY_ERR_EN
  `define STK(n) .err_sticky(ost[n]),
`else
  `define STK(n)
  initial for (int k = 0; k < N; k++) ost[k] = 1'b0;
`endif

  sr_flop_bank #(.WIDTH(1), .ILLEGAL_MODE(0), .RESET_VAL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .sr(cmd[0][1:0]), .q(qa), .qbar(qba), `STK(0) .illegal(ila));
  sr_flop_bank #(.WIDTH(1), .ILLEGAL_MODE(1), .RESET_VAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .sr(cmd[1][1:0]), .q(qb), .qbar(qbb), `STK(1) .illegal(ilb));
  sr_flop_bank #(.WIDTH(4), .ILLEGAL_MODE(3), .RESET_VAL(4'b0000)) dut_c (
    .clk(clk), .rst(rst), .sr(cmd[2][7:0]), .q(qc), .qbar(qbc), `STK(2) .illegal(ilc));
  sr_flop_bank #(.WIDTH(3), .ILLEGAL_MODE(2), .RESET_VAL(3'b101)) dut_d (
    .clk(clk), .rst(rst), .sr(cmd[3][5:0]), .q(qd), .qbar(qbd), `STK(3) .illegal(ild));
  sr_flop_bank #(.WIDTH(2), .ILLEGAL_MODE(5), .RESET_VAL(2'b10)) dut_e (
    .clk(clk), .rst(rst), .sr(cmd[4][3:0]), .q(qe), .qbar(qbe), `STK(4) .illegal(ile));

  assign oq[0] = 8'(qa);  assign oqb[0] = 8'(qba); assign oil[0] = 8'(ila);
  assign oq[1] = 8'(qb);  assign oqb[1] = 8'(qbb); assign oil[1] = 8'(ilb);
  assign oq[2] = 8'(qc);  assign oqb[2] = 8'(qbc); assign oil[2] = 8'(ilc);
  assign oq[3] = 8'(qd);  assign oqb[3] = 8'(qbd); assign oil[3] = 8'(ild);
  assign oq[4] = 8'(qe);  assign oqb[4] = 8'(qbe); assign oil[4] = 8'(ile);

  function automatic logic [7:0] msk(int w);
    return 8'((1 << w) - 1);
  endfunction

  task automatic chk(string tag, int k, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d] t=%0t got=%h expected=%h", tag, k, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("q", k, oq[k], mq[k]);
      chk("qbar", k, oqb[k], ~mq[k] & msk(W[k]));
      chk("illegal", k, oil[k], mi[k]);
`ifdef SRFF_STICKY_ERR_EN
      chk("err_sticky", k, 8'(ost[k]), 8'(ms[k]));
`endif
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k] = RV[k] & msk(W[k]);
      mi[k] = 8'h00;
      ms[k] = 1'b0;
    end
  endtask

  // one edge of the reference rules for every instance
  task automatic model_edge();
    for (int k = 0; k < N; k++) begin
      logic [7:0] nq, ni;
      nq = mq[k];
      ni = 8'h00;
      for (int i = 0; i < W[k]; i++) begin
        logic s, r;
        s = cmd[k][2*i+1];
        r = cmd[k][2*i];
        if (s && r) begin
          ni[i] = 1'b1;
          if (MODE[k] == 1)      nq[i] = ~mq[k][i];
          else if (MODE[k] == 2) nq[i] = 1'b0;
          else if (MODE[k] == 3) nq[i] = 1'b1;
        end else if (s) nq[i] = 1'b1;
        else if (r)     nq[i] = 1'b0;
      end
      mq[k] = nq;
      mi[k] = ni;
      if (ni != 8'h00) ms[k] = 1'b1;
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_all(logic [1:0] p);
    for (int k = 0; k < N; k++) begin
      cmd[k] = 16'h0;
      for (int i = 0; i < W[k]; i++) cmd[k][2*i +: 2] = p;
    end
  endtask

  task automatic set_rand();
    for (int k = 0; k < N; k++) cmd[k] = 16'($urandom) & 16'((1 << (2*W[k])) - 1);
  endtask

  task automatic async_rst();
    #3 rst = 1'b1;
    model_reset();
    #1 check_all();
  endtask

  initial begin
    rst = 1'b1;
    set_all(2'b00);
    model_reset();
    #5 check_all();
    cyc(1);
    rst = 1'b0;
    cyc(5);
    set_all(2'b10); cyc(5);
    set_all(2'b01); cyc(5);
    set_all(2'b11); cyc(5);
    set_all(2'b00); cyc(2);
    set_all(2'b10); cyc(2);
    // async reset between edges, command held while reset is high
    async_rst();
    set_all(2'b10);
    cyc(3);
    rst = 1'b0;
    cyc(2);
    // directed mixed command on the 4-bit, force-1 instance
    async_rst();
    cyc(1);
    rst = 1'b0;
    set_all(2'b00);
    cmd[2] = 16'b10_01_00_11;
    cyc(1);
    chk("mix_q", 2, oq[2], 8'b1001);
    chk("mix_ill", 2, oil[2], 8'b0001);
    // random commands with occasional async reset pulses
    for (int t = 0; t < 300; t++) begin
      set_rand();
      if ($urandom_range(0, 24) == 0) begin
        async_rst();
        cyc(1);
        rst = 1'b0;
      end else begin
        cyc(1);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Clocked, edge-triggered SR flip-flop bank with an asynchronous active-high reset.
- Default build is a single bit (WIDTH=1) driven by a 2-bit {S,R} command, with complementary outputs q/qbar.
- Used as a basic set/reset status element in control paths.
- A configurable policy for the S=R=1 command replaces the classic "undefined" state with deterministic behaviour.

Parameters:
- WIDTH, 1, number of independent SR bits in the bank.
- ILLEGAL_MODE, 0, action on S=R=1 for a bit: 0 = hold, 1 = toggle, 2 = force 0, 3 = force 1.
- RESET_VAL, 0, value of q after reset (WIDTH bits; qbar = ~RESET_VAL).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- sr, input, 2*WIDTH, command per bit i: sr[2i+1] = S, sr[2i] = R. For WIDTH=1: sr[1] = S, sr[0] = R.
- q, output, WIDTH, registered state.
- qbar, output, WIDTH, always exact bitwise complement of q.
- illegal, output, WIDTH, registered per-bit flag; 1 for the cycle following a clock edge that sampled S=R=1 on that bit.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset:
  - rst asserted forces q = RESET_VAL, qbar = ~RESET_VAL, illegal = 0 immediately, without waiting for a clock edge.
  - While rst is high, clock edges are ignored.
  - On rst deassertion, the first rising clk edge with rst low samples sr normally.
- Per bit, on each rising clk edge (rst low), sample {S,R}:
  - 00: q holds.
  - 01: q <= 0.
  - 10: q <= 1.
  - 11: action per ILLEGAL_MODE; illegal bit <= 1.
- illegal bit <= 0 for any command other than 11.
- Latency: one clock. sr changes between edges have no effect until the next rising edge. No combinational path from sr to q.
- qbar is derived from q inside the block (not an independent register), so q and qbar never equal each other, including during reset.
- Bits are fully independent. Mixed commands across bits in the same cycle are each applied per bit.
- Reset asserted mid-operation overrides any command in flight. A command sampled in the same edge as reset assertion is discarded.
- Out-of-range ILLEGAL_MODE (greater than 3) behaves as 0 (hold).

Optional Feature:
- Macro: SRFF_STICKY_ERR_EN.
- When defined:
  - Adds output err_sticky (1 bit).
  - err_sticky is set on any clock edge where any bit samples S=R=1.
  - It remains 1 until rst is asserted; it resets to 0.
  - The illegal vector is unchanged.
- When not defined:
  - The err_sticky port and its logic do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 at t=0, sr=00, clk period 20 ns → q=0, qbar=1, illegal=0 before the first edge. Release rst; hold sr=00 for 100 ns → q stays 0.
- Set: sr=10 for 100 ns → q=1, qbar=0 after the first rising edge following the change; stays 1.
- Reset command: from q=1, apply sr=01 for 100 ns → q=0, qbar=1 after the next rising edge.
- Illegal, ILLEGAL_MODE=0: from q=0, apply sr=11 for 100 ns → q holds 0, illegal=1 each cycle while 11 persists. Repeat with ILLEGAL_MODE=1 → q toggles every edge (0,1,0,1,...). With SRFF_STICKY_ERR_EN, err_sticky stays 1 after sr returns to 00.
- Async reset mid-cycle: with q=1, assert rst between edges → q=0 immediately, before the next edge. Apply sr=10 while rst is high → no change until rst is low and a rising edge occurs.
- WIDTH=4, sr = {10,01,00,11} on bits 3..0, starting from q=0000 with ILLEGAL_MODE=3 → q = 1001 after one edge, illegal = 0001.
